// File: rtl/demultiplex_1_8_serial.sv
// demultiplex_1_8_serial
// Receive side of an 8:1 serial mux path. A start pulse marks the slot-0 bit.
// The following bits fill slots 1..7 in order and are reassembled into q.
// valid pulses for one cycle on the edge that updates q.
// Optional feature macro: DEMUX_PARITY_EN. It appends a 9th even-parity bit
// after slot 7 and reports the check result on par_err.
module demultiplex_1_8_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din,
  output logic [7:0] q,
  output logic [2:0] sel,
  output logic       busy,
  output logic       valid,
  output logic       par_err
);

`ifdef DEMUX_PARITY_EN
  // With parity, slot 7 is parked in the shadow until the parity bit arrives.
  localparam int SH_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  // Without parity, slot 7 goes straight into q, so only slots 0..6 are buffered.
  localparam int SH_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [7:0]        q_q, q_d;
  logic [2:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_slot;

  assign last_slot = (sel_q == 3'd7);

  // State register; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A start pulse is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (last_slot) begin
`ifdef DEMUX_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef DEMUX_PARITY_EN
      PARITY: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: slot capture, word assembly and status flags.
  always_comb begin
    shadow_d = shadow_q;
    q_d      = q_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          shadow_d    = '0;
          shadow_d[0] = din;
          sel_d       = 3'd1;
          busy_d      = 1'b1;
        end
      end
      RECV: begin
        if (last_slot) begin
          sel_d = 3'd0;
`ifdef DEMUX_PARITY_EN
          shadow_d[7] = din;
`else
          q_d     = {din, shadow_q[6:0]};
          valid_d = 1'b1;
          busy_d  = 1'b0;
`endif
        end else begin
          shadow_d[sel_q] = din;
          sel_d           = sel_q + 3'd1;
        end
      end
`ifdef DEMUX_PARITY_EN
      PARITY: begin
        q_d     = shadow_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        sel_d   = 3'd0;
      end
`endif
      default: begin
        sel_d  = 3'd0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; a reset mid-frame drops the partial word without a valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      q_q      <= 8'h00;
      sel_q    <= 3'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      q_q      <= q_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

`ifdef DEMUX_PARITY_EN
  logic par_err_q, par_err_d;

  // Even parity: the XOR over all eight data bits and the parity bit must be 0.
  always_comb begin
    par_err_d = par_err_q;
    if (state_q == PARITY) begin
      par_err_d = (^shadow_q) ^ din;
    end
  end

  // Parity flag register; it is updated only alongside valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign q     = q_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_demultiplex_1_8_serial.sv
// Self-checking bench for demultiplex_1_8_serial.
// Inputs are driven just after each falling edge, and outputs are sampled at the falling edge.
// Frames come from a table. Reset and mid-frame-abort sequences are written by hand.
module tb_demultiplex_1_8_serial;

`ifdef DEMUX_PARITY_EN
  localparam int NB = 9;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB = 8;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       din;
  logic [7:0] q;
  logic [2:0] sel;
  logic       busy;
  logic       valid;
  logic       par_err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] held_q;

  demultiplex_1_8_serial dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .q       (q),
    .sel     (sel),
    .busy    (busy),
    .valid   (valid),
    .par_err (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       par;
    logic       b2b;
    logic       xs;
    logic [7:0] exp_q;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      din   = 1'b0;
      @(negedge clk);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sel", 32'(sel), 32'd0);
      chk("idle_q", 32'(q), 32'(held_q));
    end
  endtask

  // Sends one frame starting at the current falling edge and checks completion.
  task automatic run_frame(input logic [7:0] w, input logic p, input logic xs,
                           input logic [7:0] eq, input logic epe);
    for (int k = 0; k < NB; k++) begin
      chk("frame_sel", 32'(sel), (k < 8) ? 32'(k) : 32'd0);
      chk("frame_busy", 32'(busy), (k != 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("frame_valid", 32'(valid), 32'd0);
        chk("frame_q_hold", 32'(q), 32'(held_q));
      end
      din   = (k < 8) ? w[k] : p;
      start = (k == 0) || (xs && (k == 2 || k == 5));
      @(negedge clk);
    end
    start = 1'b0;
    din   = 1'b0;
    chk("done_valid", 32'(valid), 32'd1);
    chk("done_q", 32'(q), 32'(eq));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_sel", 32'(sel), 32'd0);
    chk("done_par_err", 32'(par_err), PAR_EN ? 32'(epe) : 32'd0);
    held_q = eq;
  endtask

  initial begin
    //          word   par   b2b   xs    exp_q  exp_pe
    vecs[0]  = '{8'hB2, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b0};
    vecs[1]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[2]  = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1};
    vecs[3]  = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[4]  = '{8'h02, 1'b1, 1'b1, 1'b0, 8'h02, 1'b0};
    vecs[5]  = '{8'h04, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0};
    vecs[6]  = '{8'h08, 1'b0, 1'b1, 1'b0, 8'h08, 1'b1};
    vecs[7]  = '{8'h10, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0};
    vecs[8]  = '{8'h20, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0};
    vecs[9]  = '{8'h40, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0};
    vecs[10] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0};
    vecs[11] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
    vecs[12] = '{8'hB2, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1};
    vecs[13] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    din    = 1'b0;
    held_q = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 14; v++) begin
      if (!vecs[v].b2b) idle(2);
      run_frame(vecs[v].word, vecs[v].par, vecs[v].xs, vecs[v].exp_q, vecs[v].exp_pe);
    end
    idle(2);

    // Abort a frame of 8'hFF at slot 4, with start also high on the reset edge.
    for (int k = 0; k < 4; k++) begin
      din   = 1'b1;
      start = (k == 0);
      @(negedge clk);
    end
    chk("abort_pre_sel", 32'(sel), 32'd4);
    chk("abort_pre_q", 32'(q), 32'h3C);
    rst   = 1'b1;
    start = 1'b1;
    din   = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst    = 1'b0;
    held_q = 8'h00;
    idle(NB);
    run_frame(8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
